// File: rtl/imem_dualport_loader.sv
// imem_dualport_loader
//   Instruction memory for a two-wide fetch port. It performs two
//   combinational word reads per cycle. A word-serial load engine fills the
//   array before execution begins. Reads return NOP_INSTR until a load has
//   completed, and they keep returning NOP_INSTR while any load is running.
//
// Ports
//   clk, reset               core clock, asynchronous active-high reset
//   imem_addr0/1, imem_ren   byte addresses for slots 0/1, shared read enable
//   imem_rdata0/1            instruction per slot (NOP when suppressed/faulting)
//   imem_fault[1:0]          per-slot misaligned / out-of-range flag (bit0 = slot 0)
//   load_start, load_base,   start a load of load_len words at byte address
//   load_len                 load_base (the low two address bits are dropped)
//   load_valid, load_data,   word-serial valid/ready write stream
//   load_ready
//   load_done                one-cycle completion pulse
//   load_err                 sticky: some word targeted an index outside the array
//   mem_loaded               array holds a completed program; reads enabled
module imem_dualport_loader #(
  parameter int                 DEPTH     = 1024,
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PC_W-1:0]            imem_addr0,
  input  logic [PC_W-1:0]            imem_addr1,
  input  logic                       imem_ren,
  output logic [INSTR_W-1:0]         imem_rdata0,
  output logic [INSTR_W-1:0]         imem_rdata1,
  output logic [1:0]                 imem_fault,
  input  logic                       load_start,
  input  logic [PC_W-1:0]            load_base,
  input  logic [$clog2(DEPTH):0]     load_len,
  input  logic                       load_valid,
  input  logic [INSTR_W-1:0]         load_data,
  output logic                       load_ready,
  output logic                       load_done,
  output logic                       load_err,
  output logic                       mem_loaded
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   base_idx_q, base_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              err_q, err_d;
  logic              loaded_q, loaded_d;

  logic [INSTR_W-1:0] mem [DEPTH];

  logic [PC_W-1:0]   wr_idx;
  logic              wr_in_range;
  logic              wr_fire;
  logic              rd_en;
  logic              fault0, fault1;

  // The word index is kept at full address width, so a base near the top of
  // the array is detected as out of range. It never wraps onto low words.
  assign wr_idx      = base_idx_q + PC_W'(cnt_q);
  assign wr_in_range = (wr_idx < PC_W'(DEPTH));

  function automatic logic slot_fault(input logic [PC_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= PC_W'(DEPTH));
  endfunction

  // ---- Load FSM: next state and outputs ----
  always_comb begin
    state_d     = state_q;
    base_idx_d  = base_idx_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    loaded_d    = loaded_q;
    load_ready  = 1'b0;
    load_done   = 1'b0;
    wr_fire     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          base_idx_d  = load_base >> 2;
          remaining_d = load_len;
          cnt_d       = '0;
          err_d       = 1'b0;
          loaded_d    = 1'b0;
          state_d     = (load_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          // Out-of-range words are dropped but still counted, so the
          // handshake length always matches load_len.
          wr_fire = wr_in_range;
          if (!wr_in_range) err_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == remaining_q - CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        load_done = 1'b1;
        loaded_d  = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- Control registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_idx_q  <= '0;
      cnt_q       <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_idx_q  <= base_idx_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      loaded_q    <= loaded_d;
    end
  end

  // ---- Array write port (contents survive reset) ----
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_idx[IDX_W-1:0]] <= load_data;
  end

  // ---- Combinational read ports ----
  assign rd_en      = imem_ren && loaded_q && (state_q == S_IDLE);
  assign fault0     = imem_ren && slot_fault(imem_addr0);
  assign fault1     = imem_ren && slot_fault(imem_addr1);
  assign imem_fault = {fault1, fault0};

  assign imem_rdata0 = (rd_en && !fault0) ? mem[imem_addr0[2 +: IDX_W]] : NOP_INSTR;
  assign imem_rdata1 = (rd_en && !fault1) ? mem[imem_addr1[2 +: IDX_W]] : NOP_INSTR;

  assign load_err   = err_q;
  assign mem_loaded = loaded_q;

endmodule

// File: tb/tb_imem_dualport_loader.sv
module tb_imem_dualport_loader;

  localparam int          DEPTH = 16;
  localparam int          LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'hD503201F;

  logic          clk;
  logic          reset;
  logic [31:0]   imem_addr0, imem_addr1;
  logic          imem_ren;
  logic [31:0]   imem_rdata0, imem_rdata1;
  logic [1:0]    imem_fault;
  logic          load_start;
  logic [31:0]   load_base;
  logic [LW-1:0] load_len;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_ready, load_done, load_err, mem_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] A [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
  logic [31:0] B [4] = '{32'hB000_0000, 32'hB111_1111, 32'hB222_2222, 32'hB333_3333};

  imem_dualport_loader #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_addr0(imem_addr0), .imem_addr1(imem_addr1), .imem_ren(imem_ren),
    .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1), .imem_fault(imem_fault),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .load_err(load_err), .mem_loaded(mem_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] base, input logic [LW-1:0] len);
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ren = 1'b0; imem_addr0 = '0; imem_addr1 = '0;
    load_start = 1'b0; load_base = '0; load_len = '0; load_valid = 1'b0; load_data = '0;
    #1;
    check("rst_ready", {31'd0, load_ready}, 32'd0);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Unloaded array reads NOP without faulting
    imem_ren = 1'b1; imem_addr0 = 32'h0; imem_addr1 = 32'h0;
    #1;
    check("unloaded_rdata0", imem_rdata0, NOP);
    check("unloaded_loaded", {31'd0, mem_loaded}, 32'd0);
    check("unloaded_fault", {30'd0, imem_fault}, 32'd0);

    // Four-word load at base 0 with a gap cycle before each word
    start_load(32'h0, LW'(4));
    check("load_ready_on", {31'd0, load_ready}, 32'd1);
    check("load_read_nop", imem_rdata0, NOP);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b0;
      tick();
      check("gap_ready", {31'd0, load_ready}, 32'd1);
      check("gap_no_done", {31'd0, load_done}, 32'd0);
      load_valid = 1'b1;
      load_data  = A[i];
      tick();
      load_valid = 1'b0;
    end
    #1;
    check("a_done_pulse", {31'd0, load_done}, 32'd1);
    check("a_done_ready", {31'd0, load_ready}, 32'd0);
    check("a_done_unloaded", {31'd0, mem_loaded}, 32'd0);
    tick();
    check("a_done_clear", {31'd0, load_done}, 32'd0);
    check("a_loaded", {31'd0, mem_loaded}, 32'd1);
    imem_addr0 = 32'h8; imem_addr1 = 32'hC;
    #1;
    check("a_rd0_A2", imem_rdata0, A[2]);
    check("a_rd1_A3", imem_rdata1, A[3]);
    imem_addr0 = 32'h4; imem_addr1 = 32'h4;
    #1;
    check("same_addr0", imem_rdata0, A[1]);
    check("same_addr1", imem_rdata1, A[1]);

    // Zero-length load goes straight to DONE and leaves the array alone
    start_load(32'h0, LW'(0));
    check("z_done", {31'd0, load_done}, 32'd1);
    check("z_unloaded", {31'd0, mem_loaded}, 32'd0);
    tick();
    check("z_loaded", {31'd0, mem_loaded}, 32'd1);
    imem_addr0 = 32'h0;
    #1;
    check("z_rd_A0", imem_rdata0, A[0]);

    // Misaligned and out-of-range reads
    imem_addr0 = 32'h6; imem_addr1 = DEPTH * 4;
    #1;
    check("bad_rd0", imem_rdata0, NOP);
    check("bad_rd1", imem_rdata1, NOP);
    check("bad_fault", {30'd0, imem_fault}, 32'd3);
    imem_addr0 = (DEPTH - 1) * 4; imem_addr1 = DEPTH * 4;
    #1;
    check("edge_fault", {30'd0, imem_fault}, 32'd2);
    imem_ren = 1'b0;
    #1;
    check("noren_fault", {30'd0, imem_fault}, 32'd0);
    check("noren_rd1", imem_rdata1, NOP);
    imem_ren = 1'b1;

    // Load running off the end of the array: two words kept, two dropped
    start_load((DEPTH - 2) * 4, LW'(4));
    load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_data = B[i];
      tick();
    end
    load_valid = 1'b0;
    #1;
    check("b_done", {31'd0, load_done}, 32'd1);
    check("b_err", {31'd0, load_err}, 32'd1);
    tick();
    check("b_loaded", {31'd0, mem_loaded}, 32'd1);
    check("b_err_sticky", {31'd0, load_err}, 32'd1);
    imem_addr0 = (DEPTH - 2) * 4; imem_addr1 = (DEPTH - 1) * 4;
    #1;
    check("b_rd0_B0", imem_rdata0, B[0]);
    check("b_rd1_B1", imem_rdata1, B[1]);
    imem_addr0 = 32'h0; imem_addr1 = 32'h4;
    #1;
    check("b_nowrap0", imem_rdata0, A[0]);
    check("b_nowrap1", imem_rdata1, A[1]);
    start_load(32'h0, LW'(0));
    check("err_cleared", {31'd0, load_err}, 32'd0);
    tick();

    // Reset in the middle of an eight-word load
    start_load(32'h0, LW'(8));
    load_valid = 1'b1;
    load_data  = 32'hC000_0000; tick();
    load_data  = 32'hC111_1111; tick();
    load_valid = 1'b0;
    check("mid_ready", {31'd0, load_ready}, 32'd1);
    reset = 1'b1;
    #1;
    check("mr_ready", {31'd0, load_ready}, 32'd0);
    check("mr_loaded", {31'd0, mem_loaded}, 32'd0);
    check("mr_rd0", imem_rdata0, NOP);
    tick();
    reset = 1'b0;
    check("mr_rd1_after", imem_rdata1, NOP);

    // Fresh load after the interrupted one
    start_load(32'h0, LW'(2));
    load_valid = 1'b1;
    load_data  = 32'hD000_0000; tick();
    load_data  = 32'hD111_1111; tick();
    load_valid = 1'b0;
    #1;
    check("d_done", {31'd0, load_done}, 32'd1);
    tick();
    check("d_loaded", {31'd0, mem_loaded}, 32'd1);
    imem_addr0 = 32'h0; imem_addr1 = 32'h4;
    #1;
    check("d_rd0", imem_rdata0, 32'hD000_0000);
    check("d_rd1", imem_rdata1, 32'hD111_1111);
    imem_addr1 = 32'h8;
    #1;
    check("d_keep_A2", imem_rdata1, A[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
